// File: rtl/arb_if_arbiter.sv
// rtl/arb_if_arbiter.sv - registered round-robin arbiter with optional hold limit
// The holder keeps the grant while requesting; a hold limit forces a handoff when others wait.
module arb_if_arbiter #(
   parameter int N        = 2,
   parameter int MAX_HOLD = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] request,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [N-1:0]  grant_nxt;
   logic [N-1:0]  masked;
   logic          others;
   logic          limit_hit;
   logic          keep;
   logic          found;
   int            sel;
   int            idx;

   always_comb begin
      others    = |(request & ~grant);
      limit_hit = (MAX_HOLD > 0) && (cnt == CW'(MAX_HOLD)) && others;
      keep      = (|(grant & request)) && !limit_hit;
      // a holder that hit its limit is excluded so the scan moves past it
      masked    = limit_hit ? (request & ~grant) : request;

      found = 1'b0;
      sel   = 0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && masked[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end

      grant_nxt = '0;
      ptr_nxt   = ptr;
      cnt_nxt   = '0;
      if (keep) begin
         grant_nxt = grant;
         if ((MAX_HOLD > 0) && (cnt != CW'(MAX_HOLD)))
            cnt_nxt = cnt + 1'b1;
         else
            cnt_nxt = cnt;
      end else if (found) begin
         grant_nxt[sel] = 1'b1;
         ptr_nxt        = PW'((sel + 1) % N);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         grant <= grant_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_arb_if_arbiter.sv
// tb/tb_arb_if_arbiter.sv - directed vector bench for arb_if_arbiter
// Two instances share stimulus: u_free (unlimited hold) and u_hold (hold limit 3).
module tb_arb_if_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] request;
   logic [1:0] grant_a;
   logic [1:0] grant_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic [1:0] req;
      logic [1:0] exp_a;
      logic [1:0] exp_b;
      string      name;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   arb_if_arbiter #(.N(2), .MAX_HOLD(0)) u_free (
      .clk     (clk),
      .rst     (rst),
      .request (request),
      .grant   (grant_a)
   );

   arb_if_arbiter #(.N(2), .MAX_HOLD(3)) u_hold (
      .clk     (clk),
      .rst     (rst),
      .request (request),
      .grant   (grant_b)
   );

   task automatic add(input logic r, input logic [1:0] q, input logic [1:0] ea,
                      input logic [1:0] eb, input string nm);
      vec_t v;
      v.rst   = r;
      v.req   = q;
      v.exp_a = ea;
      v.exp_b = eb;
      v.name  = nm;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic [1:0] q, input logic [1:0] ea,
                       input logic [1:0] eb, input string nm);
      rst     = r;
      request = q;
      @(posedge clk);
      #1;
      check({nm, "_free"}, grant_a, ea);
      check({nm, "_hold"}, grant_b, eb);
      checks++;
      if (!$onehot0(grant_a) || !$onehot0(grant_b)) begin
         errors++;
         $display("FAIL %s_onehot: got %b/%b expected onehot0", nm, grant_a, grant_b);
      end
   endtask

   initial begin
      rst     = 1'b1;
      request = 2'b00;

      add(1, 2'b00, 2'b00, 2'b00, "reset0");
      add(1, 2'b00, 2'b00, 2'b00, "reset1");
      add(0, 2'b00, 2'b00, 2'b00, "idle");
      add(0, 2'b01, 2'b01, 2'b01, "single");
      for (int i = 0; i < 5; i++) add(0, 2'b01, 2'b01, 2'b01, "single_hold");
      add(0, 2'b00, 2'b00, 2'b00, "drop_all");
      add(0, 2'b11, 2'b10, 2'b10, "ptr_after_idle");
      add(1, 2'b00, 2'b00, 2'b00, "rr_reset");
      add(0, 2'b11, 2'b01, 2'b01, "rr0");
      add(0, 2'b10, 2'b10, 2'b10, "rr1");
      add(0, 2'b01, 2'b01, 2'b01, "rr2");
      add(0, 2'b10, 2'b10, 2'b10, "rr3");
      add(0, 2'b11, 2'b10, 2'b10, "handoff_hold");
      add(0, 2'b01, 2'b01, 2'b01, "handoff_release");
      add(1, 2'b00, 2'b00, 2'b00, "limit_reset");
      add(0, 2'b11, 2'b01, 2'b01, "limit_e1");
      add(0, 2'b11, 2'b01, 2'b01, "limit_e2");
      add(0, 2'b11, 2'b01, 2'b01, "limit_e3");
      add(0, 2'b11, 2'b01, 2'b01, "limit_e4");
      add(0, 2'b11, 2'b01, 2'b10, "limit_e5");
      add(0, 2'b11, 2'b01, 2'b10, "limit_e6");
      add(0, 2'b11, 2'b01, 2'b10, "limit_e7");
      add(0, 2'b11, 2'b01, 2'b10, "limit_e8");
      add(0, 2'b11, 2'b01, 2'b01, "limit_e9");
      for (int i = 0; i < 6; i++) add(0, 2'b01, 2'b01, 2'b01, "sole_saturate");
      add(0, 2'b11, 2'b01, 2'b10, "saturated_handoff");
      add(0, 2'b00, 2'b00, 2'b00, "all_drop");

      foreach (vecs[i])
         step(vecs[i].rst, vecs[i].req, vecs[i].exp_a, vecs[i].exp_b, vecs[i].name);

      // mid-grant reset must also return the pointer to requester 0
      step(1, 2'b00, 2'b00, 2'b00, "mg_pre");
      step(0, 2'b01, 2'b01, 2'b01, "mg_grant");
      step(1, 2'b01, 2'b00, 2'b00, "mg_reset");
      step(0, 2'b11, 2'b01, 2'b01, "mg_ptr0");

      // reset while requester 1 holds
      step(0, 2'b10, 2'b10, 2'b10, "mg2_grant");
      step(1, 2'b10, 2'b00, 2'b00, "mg2_reset");
      step(0, 2'b10, 2'b10, 2'b10, "mg2_regrant");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
